// File: rtl/riscv_pkg.sv
// Shared RV32I fetch definitions: word width, bubble/illegal encodings,
// fetch FSM states and the IF/ID register layout.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [XLEN-1:0] ILLEGAL_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } ifid_t;
endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: pipeline control in, memory address/data, IF/ID view out.
// master = fetch stage, slave = surrounding pipeline / memory / bench.
interface instruction_fetch_stage_if;
  import riscv_pkg::*;

  logic            stall_i;
  logic            redirect_valid_i;
  logic [XLEN-1:0] redirect_target_i;
  logic [XLEN-1:0] imem_addr_o;
  logic [XLEN-1:0] imem_instr_i;
  logic            ifid_valid_o;
  logic [XLEN-1:0] ifid_pc_o;
  logic [XLEN-1:0] ifid_instr_o;
  logic            halted_o;
  logic [XLEN-1:0] fetch_count_o;

  modport master (
    input  stall_i, redirect_valid_i, redirect_target_i, imem_instr_i,
    output imem_addr_o, ifid_valid_o, ifid_pc_o, ifid_instr_o, halted_o, fetch_count_o
  );

  modport slave (
    output stall_i, redirect_valid_i, redirect_target_i, imem_instr_i,
    input  imem_addr_o, ifid_valid_o, ifid_pc_o, ifid_instr_o, halted_o, fetch_count_o
  );
endinterface

// File: rtl/instruction_fetch_stage_pc_reg.sv
// Program counter with next-PC select: redirect target (word aligned),
// sequential +4 (wraps mod 2^32), or hold.
module instruction_fetch_stage_pc_reg import riscv_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] target,
  input  logic            incr,
  output logic [XLEN-1:0] pc
);
  logic [XLEN-1:0] pc_d;

  // Redirect beats increment; low two bits are always cleared.
  always_comb begin
    pc_d = pc;
    if (load)      pc_d = {target[XLEN-1:2], 2'b00};
    else if (incr) pc_d = pc + 32'd4;
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= {RESET_PC[XLEN-1:2], 2'b00};
    else        pc <= pc_d;
  end
endmodule

// File: rtl/instruction_fetch_stage.sv
// RV32I fetch stage: PC drives the instruction memory address directly,
// the returned word is captured into IF/ID one cycle later. Handles
// stall, redirect, and halts on the all-zero (illegal) word.
module instruction_fetch_stage import riscv_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR,
  parameter int              BOOT_CYC  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  instruction_fetch_stage_if.master  fif
);
  localparam int BW = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;
  localparam ifid_t BUBBLE = '{valid: 1'b0, pc: '0, instr: NOP_INSTR};

  fetch_state_t    state_q, state_d;
  ifid_t           ifid_q, ifid_d;
  logic [BW-1:0]   boot_cnt;
  logic            boot_done;
  logic [XLEN-1:0] pc;
  logic            pc_load, pc_incr, cnt_inc;
  logic [XLEN-1:0] fetch_count;

  assign boot_done = (boot_cnt == BW'(BOOT_CYC - 1));

  instruction_fetch_stage_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (pc_load),
    .target (fif.redirect_target_i),
    .incr   (pc_incr),
    .pc     (pc)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // Next state, PC control and IF/ID next value; rules in priority order.
  always_comb begin
    state_d = state_q;
    ifid_d  = ifid_q;
    pc_load = 1'b0;
    pc_incr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      BOOT: begin
        // Memory is still loading; a redirect here is remembered in pc.
        pc_load = fif.redirect_valid_i;
        ifid_d  = BUBBLE;
        if (boot_done) state_d = RUN;
      end
      RUN: begin
        if (fif.redirect_valid_i) begin
          pc_load = 1'b1;
          ifid_d  = BUBBLE;
        end else if (fif.stall_i) begin
          ifid_d  = ifid_q;
        end else if (fif.imem_instr_i == ILLEGAL_ZERO) begin
          ifid_d  = BUBBLE;
          state_d = HALT;
        end else begin
          ifid_d  = '{valid: 1'b1, pc: pc, instr: fif.imem_instr_i};
          pc_incr = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      HALT: ifid_d = BUBBLE;  // terminal until reset; redirects ignored
      default: begin
        state_d = BOOT;
        ifid_d  = BUBBLE;
      end
    endcase
  end

  // Boot cycle counter; only meaningful while in BOOT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              boot_cnt <= '0;
    else if (state_q == BOOT && !boot_done) boot_cnt <= boot_cnt + 1'b1;
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ifid_q <= BUBBLE;
    else        ifid_q <= ifid_d;
  end

  // Count of valid instructions handed to decode; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       fetch_count <= '0;
    else if (cnt_inc) fetch_count <= fetch_count + 32'd1;
  end

  assign fif.imem_addr_o   = pc;
  assign fif.ifid_valid_o  = ifid_q.valid;
  assign fif.ifid_pc_o     = ifid_q.pc;
  assign fif.ifid_instr_o  = ifid_q.valid ? ifid_q.instr : NOP_INSTR;
  assign fif.halted_o      = (state_q == HALT);
  assign fif.fetch_count_o = fetch_count;
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a small combinational
// instruction memory and an IF/ID expectation queue.
module tb_instruction_fetch_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_stage_if fif ();

  instruction_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013),
    .BOOT_CYC (1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .fif  (fif)
  );

  // Program: addi x2,x0,5 / addi x1,x0,10 / add x3,x1,x2 / and x4,x1,x2 / or x5,x1,x2
  logic [31:0] prog [0:7];
  logic [31:0] hi_word;
  initial begin
    prog[0] = 32'h0050_0113;
    prog[1] = 32'h00A0_0093;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h0020_F233;
    prog[4] = 32'h0020_E2B3;
    prog[5] = 32'h0;
    prog[6] = 32'h0;
    prog[7] = 32'h0;
    hi_word = 32'h0010_0093;
  end

  assign fif.imem_instr_i = (fif.imem_addr_o == 32'hFFFF_FFFC) ? hi_word :
                            (fif.imem_addr_o < 32'd32) ? prog[fif.imem_addr_o[4:2]] : 32'h0;

  int n_cmp = 0;
  int n_err = 0;
  ifid_t exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"}, {31'b0, fif.ifid_valid_o}, 32'd0);
    chk({tag, ".pc"},    fif.ifid_pc_o, 32'd0);
    chk({tag, ".instr"}, fif.ifid_instr_o, 32'h0000_0013);
    chk({tag, ".halt"},  {31'b0, fif.halted_o}, 32'd0);
    chk({tag, ".cnt"},   fif.fetch_count_o, 32'd0);
    chk({tag, ".addr"},  fif.imem_addr_o, 32'd0);
  endtask

  // Push the IF/ID contents expected after the next edge, clock, then pop/compare.
  task automatic tick(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    ifid_t e;
    exp_q.push_back('{valid: v, pc: pc, instr: ins});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".valid"}, {31'b0, fif.ifid_valid_o}, {31'b0, e.valid});
    chk({tag, ".instr"}, fif.ifid_instr_o, e.instr);
    if (e.valid) chk({tag, ".pc"}, fif.ifid_pc_o, e.pc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    fif.stall_i           = 1'b0;
    fif.redirect_valid_i  = 1'b0;
    fif.redirect_target_i = 32'h0;
    #2;
    chk_reset("rst0");
    do_reset();

    // Straight run to halt
    tick("boot", 1'b0, 32'h0, NOP);
    for (int i = 0; i < 5; i++) tick("run", 1'b1, 32'(i * 4), prog[i]);
    chk("run.cnt", fif.fetch_count_o, 32'd5);
    tick("halt", 1'b0, 32'h0, NOP);
    chk("halt.flag", {31'b0, fif.halted_o}, 32'd1);
    chk("halt.addr", fif.imem_addr_o, 32'h14);

    // Redirect in HALT is ignored
    fif.redirect_valid_i = 1'b1; fif.redirect_target_i = 32'h0;
    tick("hredir", 1'b0, 32'h0, NOP);
    fif.redirect_valid_i = 1'b0;
    chk("hredir.flag", {31'b0, fif.halted_o}, 32'd1);
    chk("hredir.addr", fif.imem_addr_o, 32'h14);
    chk("hredir.cnt", fif.fetch_count_o, 32'd5);

    // Stall for three cycles at PC 8
    do_reset();
    tick("boot2", 1'b0, 32'h0, NOP);
    tick("s.pc0", 1'b1, 32'h0, prog[0]);
    tick("s.pc4", 1'b1, 32'h4, prog[1]);
    fif.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("stall", 1'b1, 32'h4, 32'h00A0_0093);
      chk("stall.addr", fif.imem_addr_o, 32'h8);
      chk("stall.cnt", fif.fetch_count_o, 32'd2);
    end
    fif.stall_i = 1'b0;
    tick("unstall", 1'b1, 32'h8, prog[2]);
    chk("unstall.cnt", fif.fetch_count_o, 32'd3);

    // Redirect overrides stall; target low bits dropped
    fif.stall_i = 1'b1; fif.redirect_valid_i = 1'b1; fif.redirect_target_i = 32'h0000_0006;
    tick("redir", 1'b0, 32'h0, NOP);
    fif.stall_i = 1'b0; fif.redirect_valid_i = 1'b0;
    chk("redir.addr", fif.imem_addr_o, 32'h4);
    chk("redir.cnt", fif.fetch_count_o, 32'd3);
    tick("redir.nxt", 1'b1, 32'h4, prog[1]);
    chk("redir.cnt2", fif.fetch_count_o, 32'd4);

    // PC wrap at the top of the address space
    fif.redirect_valid_i = 1'b1; fif.redirect_target_i = 32'hFFFF_FFFF;
    tick("wrap.rd", 1'b0, 32'h0, NOP);
    fif.redirect_valid_i = 1'b0;
    chk("wrap.addr0", fif.imem_addr_o, 32'hFFFF_FFFC);
    tick("wrap", 1'b1, 32'hFFFF_FFFC, hi_word);
    chk("wrap.addr1", fif.imem_addr_o, 32'h0);
    tick("w.pc0", 1'b1, 32'h0, prog[0]);
    tick("w.pc4", 1'b1, 32'h4, prog[1]);
    tick("w.pc8", 1'b1, 32'h8, prog[2]);
    chk("w.addr", fif.imem_addr_o, 32'hC);

    // Asynchronous reset mid-cycle while in RUN at PC 0xC
    #2 rst_n = 1'b0;
    #1;
    chk_reset("arst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick("boot3", 1'b0, 32'h0, NOP);
    tick("r.pc0", 1'b1, 32'h0, prog[0]);
    chk("r.cnt", fif.fetch_count_o, 32'd1);

    // Redirect during BOOT is latched, BOOT still lasts one cycle
    do_reset();
    fif.redirect_valid_i = 1'b1; fif.redirect_target_i = 32'h0000_0009;
    tick("bredir", 1'b0, 32'h0, NOP);
    fif.redirect_valid_i = 1'b0;
    chk("bredir.addr", fif.imem_addr_o, 32'h8);
    tick("bredir.nxt", 1'b1, 32'h8, prog[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
